// File: rtl/reg_bank_pkg.sv
// Shared constants, storage typedefs and FSM state encoding for the reg_bank register file.
// Optional write-through forwarding in reg_bank is enabled by defining REG_BANK_BYPASS_EN.
package reg_bank_pkg;

  localparam int NUM_REGS = 32;
  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

  typedef logic [DATA_W-1:0]                word_t;
  typedef logic [NUM_REGS-1:0][DATA_W-1:0]  reg_array_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/reg_bank_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by reservations and cleared
// by writebacks or by the flush sweep. Register 31 is never reservable.
module reg_bank_scoreboard
  import reg_bank_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                idle,
  input  logic                rsv_valid,
  input  logic [ADDR_W-1:0]   rsv_addr,
  input  logic                wr_accept,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic                clr_en,
  input  logic [ADDR_W-1:0]   clr_addr,
  output logic                rsv_ready,
  output logic [NUM_REGS-1:0] busy
);

  logic [NUM_REGS-1:0] busy_reg;
  logic [NUM_REGS-1:0] busy_next;
  logic                rsv_accept;

  assign rsv_ready  = idle && !busy_reg[rsv_addr] && (rsv_addr != ZERO_REG);
  assign rsv_accept = rsv_valid && rsv_ready;
  assign busy       = busy_reg;

  // A reservation beats a same-edge write to the same index, so the new consumer still waits.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_busy
    assign busy_next[gi] = (clr_en && clr_addr == ADDR_W'(gi))         ? 1'b0 :
                           (rsv_accept && rsv_addr == ADDR_W'(gi))     ? 1'b1 :
                           (wr_accept && wr_addr == ADDR_W'(gi))       ? 1'b0 :
                           busy_reg[gi];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

endmodule

// File: rtl/reg_bank.sv
// 32 x 64-bit register file with hardwired-zero X31, reservation scoreboard and a
// 32-cycle sequential flush. Define REG_BANK_BYPASS_EN for same-cycle write forwarding.
module reg_bank
  import reg_bank_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  word_t               wr_data,
  input  logic                rsv_valid,
  input  logic [ADDR_W-1:0]   rsv_addr,
  output logic                rsv_ready,
  input  logic                flush,
  output logic                flush_done,
  output reg_array_t          regs,
  output logic [NUM_REGS-1:0] busy
);

  state_t            state_reg;
  logic [ADDR_W-1:0] cnt_reg;
  logic              flush_done_reg;
  logic              wr_accept;
  logic              flushing;
  reg_array_t        stored;

  assign flushing   = (state_reg == FLUSH);
  assign wr_ready   = (state_reg == IDLE);
  assign wr_accept  = wr_valid && wr_ready;
  assign flush_done = flush_done_reg;

  // The counter wraps 31 -> 0 on the same edge that leaves FLUSH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      flush_done_reg <= 1'b0;
    end else begin
      flush_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (flush) begin
            state_reg <= FLUSH;
            cnt_reg   <= '0;
          end
        end
        FLUSH: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == ZERO_REG) begin
            state_reg      <= IDLE;
            flush_done_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // X31 has no storage; writes addressed to it simply match no register.
  for (genvar gi = 0; gi < NUM_REGS - 1; gi++) begin : g_reg
    word_t data_reg;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        data_reg <= '0;
      end else if (flushing && cnt_reg == ADDR_W'(gi)) begin
        data_reg <= '0;
      end else if (wr_accept && wr_addr == ADDR_W'(gi)) begin
        data_reg <= wr_data;
      end
    end

    assign stored[gi] = data_reg;
  end

  assign stored[NUM_REGS-1] = '0;

`ifdef REG_BANK_BYPASS_EN
  always_comb begin
    regs = stored;
    if (wr_accept && wr_addr != ZERO_REG) begin
      regs[wr_addr] = wr_data;
    end
  end
`else
  assign regs = stored;
`endif

  reg_bank_scoreboard u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .idle      (wr_ready),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .wr_accept (wr_accept),
    .wr_addr   (wr_addr),
    .clr_en    (flushing),
    .clr_addr  (cnt_reg),
    .rsv_ready (rsv_ready),
    .busy      (busy)
  );

endmodule
